// File: rtl/hamming_pkg.sv
// Shared Hamming (15+1) codeword layout: widths, data-bit positions and data extraction.
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 16;
    localparam int SYN_W  = 4;

    // Codeword index of each data bit; the encoder places data bits at the same indices.
    localparam int DATA_POS [0:DATA_W-1] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] codeword);
        logic [DATA_W-1:0] data;
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = codeword[DATA_POS[i]];
        end
        return data;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for one 16-bit Hamming codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] codeword,
    output logic [SYN_W-1:0]  syndrome,
    output logic              parity
);

    // Index 0 contributes nothing to the XOR, so starting at 0 is harmless.
    always_comb begin
        syndrome = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (codeword[i]) begin
                syndrome = syndrome ^ SYN_W'(i);
            end
        end
    end

    assign parity = ^codeword;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage valid/ready Hamming decoder with saturating error counters.
// Define SECDED_EN to check bit0 as overall parity and flag double errors.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_single,
    output logic              err_double,
    output logic [SYN_W-1:0]  err_pos,
    input  logic              clr_counts,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);

    logic              s1Valid;
    logic [CODE_W-1:0] s1Code;
    logic [SYN_W-1:0]  s1Syn;
    logic [SYN_W-1:0]  synNext;
`ifdef SECDED_EN
    logic              s1Par;
    logic              parNext;
`else
    logic              unusedPar;
`endif
    logic              s1Load;
    logic              s2Load;
    logic              outXfer;
    logic [CODE_W-1:0] fixedCode;
    logic              decSingle;
    logic              decDouble;
    logic [SYN_W-1:0]  decPos;

    hamming_syndrome uSyndrome (
        .codeword (code_in),
        .syndrome (synNext),
`ifdef SECDED_EN
        .parity   (parNext)
`else
        .parity   (unusedPar)
`endif
    );

    assign s2Load   = !out_valid || out_ready;
    assign s1Load   = !s1Valid || s2Load;
    assign in_ready = s1Load;
    assign outXfer  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Code  <= '0;
            s1Syn   <= '0;
`ifdef SECDED_EN
            s1Par   <= 1'b0;
`endif
        end else if (s1Load) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Code <= code_in;
                s1Syn  <= synNext;
`ifdef SECDED_EN
                s1Par  <= parNext;
`endif
            end
        end
    end

    // A double error leaves the data uncorrected; a bit0-only flip needs no data fix.
    always_comb begin
        fixedCode = s1Code;
        decSingle = 1'b0;
        decDouble = 1'b0;
        decPos    = '0;
`ifdef SECDED_EN
        if (s1Par) begin
            decSingle = 1'b1;
            decPos    = s1Syn;
            if (s1Syn != '0) begin
                fixedCode[s1Syn] = ~s1Code[s1Syn];
            end
        end else if (s1Syn != '0) begin
            decDouble = 1'b1;
        end
`else
        if (s1Syn != '0) begin
            decSingle        = 1'b1;
            decPos           = s1Syn;
            fixedCode[s1Syn] = ~s1Code[s1Syn];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            err_pos    <= '0;
        end else if (s2Load) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                data_out   <= extract_data(fixedCode);
                err_single <= decSingle;
                err_double <= decDouble;
                err_pos    <= decPos;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else begin
            if (outXfer && err_single && (corr_count != {CNT_W{1'b1}})) begin
                corr_count <= corr_count + 1'b1;
            end
            if (outXfer && err_double && (uncorr_count != {CNT_W{1'b1}})) begin
                uncorr_count <= uncorr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed table-driven bench for hamming_secded_decoder; expectations follow the SECDED_EN setting.
module tb_hamming_secded_decoder;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    typedef struct {
        logic [15:0] code;
        logic [10:0] data;
        logic        single;
        logic        dbl;
        logic [3:0]  pos;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [15:0]         code_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [10:0]         data_out;
    logic                err_single;
    logic                err_double;
    logic [3:0]          err_pos;
    logic                clr_counts = 1'b0;
    logic [TB_CNT_W-1:0] corr_count;
    logic [TB_CNT_W-1:0] uncorr_count;

    int   nTests = 0;
    int   nFail = 0;
    int   modelCorr = 0;
    int   modelUncorr = 0;
    vec_t vecs [8];
    vec_t expQ [$];

    hamming_secded_decoder #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .code_in      (code_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .err_single   (err_single),
        .err_double   (err_double),
        .err_pos      (err_pos),
        .clr_counts   (clr_counts),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", nTests);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic count_output(input vec_t v);
        if (v.single && modelCorr < CNT_MAX) modelCorr++;
        if (v.dbl && modelUncorr < CNT_MAX) modelUncorr++;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, "_valid"},  32'(out_valid),  32'd1);
        check({tag, "_data"},   32'(data_out),   32'(v.data));
        check({tag, "_single"}, 32'(err_single), 32'(v.single));
        check({tag, "_double"}, 32'(err_double), 32'(v.dbl));
        check({tag, "_pos"},    32'(err_pos),    32'(v.pos));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_corr"},   32'(corr_count),   32'(modelCorr));
        check({tag, "_uncorr"}, 32'(uncorr_count), 32'(modelUncorr));
    endtask

    // One word through an idle pipeline: accept, 2-edge latency, then consume.
    task automatic send_check(input string tag, input vec_t v);
        int waitCnt = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        code_in   = v.code;
        while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_out(tag, v);
        @(posedge clk); #1;
        count_output(v);
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
        check_counts(tag);
    endtask

    initial begin
        vec_t bp [3];
        int   accepted;
        int   got;
        int   idleValid;

`ifdef SECDED_EN
        vecs[0] = '{16'hB41E, 11'h5A1, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{16'hB45E, 11'h5A1, 1'b1, 1'b0, 4'd6};
        vecs[2] = '{16'hB65E, 11'h5B5, 1'b0, 1'b1, 4'd0};
        vecs[3] = '{16'hB41F, 11'h5A1, 1'b1, 1'b0, 4'd0};
        vecs[4] = '{16'h0000, 11'h000, 1'b0, 1'b0, 4'd0};
        vecs[5] = '{16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0};
        vecs[6] = '{16'h341E, 11'h5A1, 1'b1, 1'b0, 4'd15};
        vecs[7] = '{16'hB436, 11'h5A2, 1'b0, 1'b1, 4'd0};
`else
        vecs[0] = '{16'hB41E, 11'h5A1, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{16'hB45E, 11'h5A1, 1'b1, 1'b0, 4'd6};
        vecs[2] = '{16'hB65E, 11'h1B5, 1'b1, 1'b0, 4'd15};
        vecs[3] = '{16'hB41F, 11'h5A1, 1'b0, 1'b0, 4'd0};
        vecs[4] = '{16'h0000, 11'h000, 1'b0, 1'b0, 4'd0};
        vecs[5] = '{16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0};
        vecs[6] = '{16'h341E, 11'h5A1, 1'b1, 1'b0, 4'd15};
        vecs[7] = '{16'hB436, 11'h5A6, 1'b1, 1'b0, 4'd6};
`endif

        // Clock/reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid",  32'(out_valid),    32'd0);
        check("rst_data",       32'(data_out),     32'd0);
        check("rst_single",     32'(err_single),   32'd0);
        check("rst_double",     32'(err_double),   32'd0);
        check("rst_pos",        32'(err_pos),      32'd0);
        check("rst_corr",       32'(corr_count),   32'd0);
        check("rst_uncorr",     32'(uncorr_count), 32'd0);
        check("rst_in_ready",   32'(in_ready),     32'd1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            send_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: stall the output, offer 3 words
        bp[0] = vecs[0];
        bp[1] = vecs[1];
        bp[2] = vecs[4];
        accepted = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (accepted < 3) begin
                in_valid = 1'b1;
                code_in  = bp[accepted].code;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                expQ.push_back(bp[accepted]);
                accepted++;
            end
            @(negedge clk);
        end
        #1;
        check("bp_accepted_stalled", 32'(accepted),  32'd2);
        check("bp_in_ready_low",     32'(in_ready),  32'd0);
        check("bp_hold_valid",       32'(out_valid), 32'd1);
        check("bp_hold_data",        32'(data_out),  32'(bp[0].data));
        check("bp_hold_pos",         32'(err_pos),   32'(bp[0].pos));

        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (accepted < 3) begin
                in_valid = 1'b1;
                code_in  = bp[accepted].code;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    check("bp_unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    vec_t v;
                    v = expQ.pop_front();
                    check_out($sformatf("bp_out%0d", got), v);
                    count_output(v);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(bp[accepted]);
                accepted++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("bp_accepted_total", 32'(accepted),    32'd3);
        check("bp_outputs_total",  32'(got),         32'd3);
        check("bp_queue_empty",    32'(expQ.size()), 32'd0);
        check_counts("bp");

        // Saturation of corr_count
        while (modelCorr < CNT_MAX - 1) begin
            send_check("sat_fill", vecs[1]);
        end
        check("sat_max_minus_1", 32'(corr_count), 32'(CNT_MAX - 1));
        send_check("sat_hit", vecs[1]);
        send_check("sat_hold", vecs[1]);
        check("sat_max", 32'(corr_count), 32'(CNT_MAX));

        // clr_counts in the same cycle as an increment
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = vecs[1].code;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_out("clr_word", vecs[1]);
        @(negedge clk);
        out_ready  = 1'b1;
        clr_counts = 1'b1;
        @(posedge clk); #1;
        clr_counts  = 1'b0;
        modelCorr   = 0;
        modelUncorr = 0;
        check("clr_drained", 32'(out_valid), 32'd0);
        check_counts("clr_same_cycle");
        send_check("clr_resume", vecs[6]);

        // Reset with the pipeline full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = vecs[1].code;
        @(posedge clk); #1;
        code_in = vecs[2].code;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready),  32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        modelCorr   = 0;
        modelUncorr = 0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check_counts("midrst");
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        idleValid = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid) idleValid++;
        end
        check("midrst_no_ghost_out", 32'(idleValid), 32'd0);
        send_check("post_rst", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Downstream neighbour of the 15+1 Hamming encoder; consumes its 16-bit codewords after storage/transmission.
- Recovers the 11 data bits, corrects any single-bit error and flags uncorrectable words.
- 2-stage valid/ready pipeline with saturating error-statistics counters for the test harness and the LED/UART reporting path.

Parameters:
- CNT_W, 16, width of each saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  code_in holds a codeword
- in_ready  output  1  block accepts code_in this cycle
- code_in  input  16  codeword; bit0 overall parity; bits 1,2,4,8 = parity[0..3]; bits 3,5,6,7,9..15 = data[0..10] in ascending order
- out_valid  output  1  data_out and flags valid
- out_ready  input  1  consumer takes the output this cycle
- data_out  output  11  corrected data
- err_single  output  1  single-bit error detected (and corrected)
- err_double  output  1  uncorrectable error detected
- err_pos  output  4  bit position corrected (0 = none, or bit0 flip)
- clr_counts  input  1  one-cycle pulse, clears both counters
- corr_count  output  CNT_W  words with err_single
- uncorr_count  output  CNT_W  words with err_double

Behaviour:
- Reset: out_valid=0, data_out=0, err_single=0, err_double=0, err_pos=0, counters=0, stage-1 valid=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight words; no output is produced for them.
- Transfer rules: a transfer occurs on a cycle where valid and ready are both high. Outputs hold stable while out_valid=1 and out_ready=0.
- Stage 1 (S1) registers:
  - syndrome s = XOR of indices i (1..15) where code_in[i]=1.
  - overall parity p = XOR of code_in[15:0].
  - the raw codeword.
- Stage 2 (S2, output register) loads when !out_valid || out_ready.
- S1 loads when !s1_valid || s2_load. in_ready = !s1_valid || s2_load.
- Full throughput is 1 word/cycle. Latency is 2 cycles from the in transfer to out_valid.
- Decode with SECDED_EN defined:
  - s=0,p=0: clean.
  - s!=0,p=1: flip bit s; err_single=1; err_pos=s.
  - s=0,p=1: bit0 flipped; err_single=1; err_pos=0; data unaffected.
  - s!=0,p=0: err_double=1; err_pos=0; data_out = raw extracted data, uncorrected.
- err_single and err_double are never both 1.
- Counters:
  - Increment once per output transfer whose flag is set.
  - Saturate at 2^CNT_W-1.
  - clr_counts has priority; an increment in the same cycle is dropped and the counter reads 0.

Optional Feature:
- Macro SECDED_EN.
- Defined: bit0 is checked as even overall parity and double errors are detected, as in the decode table above.
- Undefined: bit0 is ignored, p is not computed, err_double is tied to 0 and uncorr_count stays 0. Any s!=0 is corrected with err_single=1 and err_pos=s.
- Without SECDED_EN the decoder accepts the encoder's current bit0=0 output.

Decomposition:
- Package hamming_pkg holds:
  - DATA_W=11, CODE_W=16, SYN_W=4.
  - Constant array DATA_POS[0:10] = {3,5,6,7,9,10,11,12,13,14,15}, shared with the encoder.
  - Function extract_data(codeword).
- One sub-module hamming_syndrome (combinational: codeword -> s, p) used by S1.

Test Plan:
- Clean word: code_in=16'hB41E -> 2 cycles later out_valid=1, data_out=11'h5A1, err_single=0, err_double=0, err_pos=0.
- Single-bit error: code_in=16'hB45E (bit6 flipped) -> data_out=11'h5A1, err_single=1, err_pos=6; corr_count increments by 1.
- Double-bit error: code_in=16'hB65E (bits 6 and 9 flipped).
  - SECDED_EN defined: err_double=1, err_pos=0, uncorr_count=1.
  - SECDED_EN undefined: err_single=1, err_pos=15.
- Parity-bit error: code_in=16'hB41F.
  - SECDED_EN defined: err_single=1, err_pos=0, data_out=11'h5A1.
  - SECDED_EN undefined: clean.
- Backpressure: hold out_ready=0 and stream 3 words -> in_ready=0 after 2 accepts. Release -> all 3 emerge in order, none lost or duplicated.
- Counters and reset:
  - Force corr_count to max-1, send 2 single-error words -> counter stays at max.
  - clr_counts asserted in the same cycle as an increment -> counter reads 0.
  - rst asserted with the pipeline full -> next cycle out_valid=0 and in_ready=1.
